// File: rtl/dct_even_stage.sv
// Even half of the 8-point 1-D DCT.
// Takes the four add_up pair sums, forms the butterfly terms and produces
// X0, X2, X4, X6 with one time-shared signed multiplier over a six-step
// schedule. Results and out_valid update together at the last step.
module dct_even_stage #(
    parameter int IN_W   = 18,
    parameter int COEF_W = 16,
    parameter int OUT_W  = 20,
    parameter int C4     = 5793,
    parameter int C2     = 7568,
    parameter int C6     = 3135
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IN_W-1:0]  s0,
    input  logic [IN_W-1:0]  s1,
    input  logic [IN_W-1:0]  s2,
    input  logic [IN_W-1:0]  s3,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [OUT_W-1:0] X0,
    output logic [OUT_W-1:0] X2,
    output logic [OUT_W-1:0] X4,
    output logic [OUT_W-1:0] X6,
    output logic             out_valid
);

    localparam int SUM_W  = IN_W + 3;
    localparam int PROD_W = COEF_W + SUM_W;
    localparam int ACC_W  = PROD_W + 1;
    localparam int FRAC   = COEF_W - 2;

    localparam logic signed [ACC_W-1:0] HALF = ACC_W'(1 << (FRAC - 1));

    typedef enum logic [1:0] {
        IDLE,
        BFLY,
        MUL,
        DONE
    } state_t;

    state_t state;
    state_t state_nxt;

    logic signed [IN_W-1:0]   r0, r1, r2, r3;
    logic signed [SUM_W-1:0]  a, b, c, d;
    logic [2:0]               cnt;

    logic signed [COEF_W-1:0] coef;
    logic signed [SUM_W-1:0]  op;
    logic signed [PROD_W-1:0] prod;
    logic signed [PROD_W-1:0] hold;
    logic signed [ACC_W-1:0]  acc_sum;
    logic signed [ACC_W-1:0]  acc_dif;

    logic signed [OUT_W-1:0]  x0c, x2c, x4c;

    // Round half up at the Q1.14 binary point, then keep the low OUT_W bits.
    function automatic logic signed [OUT_W-1:0] rnd(input logic signed [ACC_W-1:0] v);
        logic signed [ACC_W-1:0] t;
        t = v + HALF;
        t = t >>> FRAC;
        return OUT_W'(t);
    endfunction

    assign in_ready = (state == IDLE);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = BFLY;
            BFLY:    state_nxt = MUL;
            MUL:     if (cnt == 3'd5) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Multiplier operand schedule, one product per MUL step.
    always_comb begin
        coef = '0;
        op   = '0;
        case (cnt)
            3'd0: begin coef = COEF_W'(C4); op = a + b; end
            3'd1: begin coef = COEF_W'(C4); op = a - b; end
            3'd2: begin coef = COEF_W'(C2); op = c;     end
            3'd3: begin coef = COEF_W'(C6); op = d;     end
            3'd4: begin coef = COEF_W'(C6); op = c;     end
            default: begin coef = COEF_W'(C2); op = d;  end
        endcase
        prod    = PROD_W'(coef) * PROD_W'(op);
        acc_sum = ACC_W'(hold) + ACC_W'(prod);
        acc_dif = ACC_W'(hold) - ACC_W'(prod);
    end

    // Datapath: capture, butterfly, product sequencing and output update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r0        <= '0;
            r1        <= '0;
            r2        <= '0;
            r3        <= '0;
            a         <= '0;
            b         <= '0;
            c         <= '0;
            d         <= '0;
            cnt       <= '0;
            hold      <= '0;
            x0c       <= '0;
            x2c       <= '0;
            x4c       <= '0;
            X0        <= '0;
            X2        <= '0;
            X4        <= '0;
            X6        <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        r0 <= s0;
                        r1 <= s1;
                        r2 <= s2;
                        r3 <= s3;
                    end
                end
                BFLY: begin
                    a   <= SUM_W'(r0) + SUM_W'(r3);
                    b   <= SUM_W'(r1) + SUM_W'(r2);
                    c   <= SUM_W'(r0) - SUM_W'(r3);
                    d   <= SUM_W'(r1) - SUM_W'(r2);
                    cnt <= '0;
                end
                MUL: begin
                    cnt <= cnt + 3'd1;
                    case (cnt)
                        3'd0: x0c  <= rnd(ACC_W'(prod));
                        3'd1: x4c  <= rnd(ACC_W'(prod));
                        3'd2: hold <= prod;
                        3'd3: x2c  <= rnd(acc_sum);
                        3'd4: hold <= prod;
                        3'd5: begin
                            X0        <= x0c;
                            X2        <= x2c;
                            X4        <= x4c;
                            X6        <= rnd(acc_dif);
                            out_valid <= 1'b1;
                        end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

endmodule
